// File: rtl/cpu_types_pkg.sv
// Shared CPU-side types: RAM status and arbiter grant owner.
// Latency: n/a (types only).
// Backpressure: n/a.
package cpu_types_pkg;

    // RAM model status as seen by the memory-side responder.
    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    // Which cache held the most recent completed grant.
    typedef enum logic {
        INSTR = 1'b0,
        DATA  = 1'b1
    } grant_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear and a reached-max flag.
// Latency: count updates on the edge after clr/en; at_max is combinational from the count.
// Backpressure: none; holds at MAX instead of wrapping.
//
// Ports: CLK, nRST (async, active low), clr (clear to 0, wins over en),
//        en (count up), at_max (count == MAX).
module sat_counter #(
    parameter int W   = 8,
    parameter int MAX = 255
) (
    input  logic CLK,
    input  logic nRST,
    input  logic clr,
    input  logic en,
    output logic at_max
);

    logic [W-1:0] cnt;

    assign at_max = (cnt == W'(MAX));

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && !at_max) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/cache_mem_arbiter.sv
// Arbitrates icache reads and dcache reads/writes onto one RAM port, round-robin on ties.
// Latency: 1 cycle to grant, completion in the first grant cycle with ACCESS (min 2 cycles).
// Backpressure: iwait/dwait stay high until completion; a grant is held until done, aborted or timed out.
//
// Ports: CLK, nRST (async, active low)
//        icache: iREN, iaddr -> iwait, iload
//        dcache: dREN, dWEN, daddr, dstore -> dwait, dload
//        RAM:    ramREN, ramWEN, ramaddr, ramstore <- ramload, ramstate
//        bus_err: sticky error/timeout flag, cleared only by reset
module cache_mem_arbiter
    import cpu_types_pkg::*;
#(
    parameter int          TIMEOUT_CYC = 255,
    parameter logic [31:0] ERR_WORD    = 32'hBAD1BAD1
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        iREN,
    input  logic [31:0] iaddr,
    output logic        iwait,
    output logic [31:0] iload,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic        dwait,
    output logic [31:0] dload,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  ramstate_t   ramstate,
    output logic        bus_err
);

    localparam int CW = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        IGNT = 2'd1,
        DGNT = 2'd2
    } arb_state_t;

    arb_state_t state;
    grant_t     last_grant;

    logic dreq;
    logic i_act;
    logic d_act;
    logic acc;
    logic err_st;
    logic tmo;
    logic done;
    logic fail;
    logic cnt_clr;
    logic cnt_en;

    assign dreq   = dREN || dWEN;
    // A grant is only live while its requester still asserts; a dropped
    // request kills the RAM enables in the same cycle.
    assign i_act  = (state == IGNT) && iREN;
    assign d_act  = (state == DGNT) && dreq;
    assign acc    = (ramstate == ACCESS);
    assign err_st = (ramstate == ERROR);
    assign done   = (i_act || d_act) && (acc || err_st || tmo);
    // ACCESS beats a coincident timeout, so it never counts as a failure.
    assign fail   = (i_act || d_act) && !acc && (err_st || tmo);

    // The counter holds the number of grant cycles already spent waiting, so
    // reaching TIMEOUT_CYC-1 in a cycle without ACCESS makes it the
    // TIMEOUT_CYC-th waiting cycle, which is where the abort happens.
    assign cnt_clr = (state == IDLE);
    assign cnt_en  = (state != IDLE) && !acc && !err_st;

    sat_counter #(
        .W   (CW),
        .MAX (TIMEOUT_CYC - 1)
    ) u_tmo_cnt (
        .CLK    (CLK),
        .nRST   (nRST),
        .clr    (cnt_clr),
        .en     (cnt_en),
        .at_max (tmo)
    );

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state      <= IDLE;
            last_grant <= INSTR;
            bus_err    <= 1'b0;
        end else begin
            if (fail) begin
                bus_err <= 1'b1;
            end
            case (state)
                IDLE: begin
                    // dcache wins a tie unless it had the previous grant.
                    if (dreq && !(iREN && last_grant == DATA)) begin
                        state <= DGNT;
                    end else if (iREN) begin
                        state <= IGNT;
                    end
                end
                IGNT: begin
                    if (!iREN) begin
                        state <= IDLE;
                    end else if (done) begin
                        state      <= IDLE;
                        last_grant <= INSTR;
                    end
                end
                DGNT: begin
                    if (!dreq) begin
                        state <= IDLE;
                    end else if (done) begin
                        state      <= IDLE;
                        last_grant <= DATA;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        iwait    = 1'b1;
        dwait    = 1'b1;
        iload    = '0;
        dload    = '0;
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        if (i_act) begin
            ramREN  = 1'b1;
            ramaddr = iaddr;
            if (done) begin
                iwait = 1'b0;
                iload = fail ? ERR_WORD : ramload;
            end
        end
        if (d_act) begin
            ramaddr = daddr;
            if (dWEN) begin
                ramWEN   = 1'b1;
                ramstore = dstore;
            end else begin
                ramREN = 1'b1;
            end
            if (done) begin
                dwait = 1'b0;
                dload = fail ? ERR_WORD : ramload;
            end
        end
    end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Bench for cache_mem_arbiter: scenario tasks drive the caches and RAM status per cycle.
// Latency: completions are expected in the exact cycle they are queued.
// Backpressure: RAM status is scripted per cycle (FREE/BUSY/ACCESS/ERROR).
module tb_cache_mem_arbiter;
    import cpu_types_pkg::*;

    localparam logic [31:0] ERRW = 32'hBAD1BAD1;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        iREN, dREN, dWEN;
    logic [31:0] iaddr, daddr, dstore, ramload;
    logic        iwait, dwait, ramREN, ramWEN, bus_err;
    logic [31:0] iload, dload, ramaddr, ramstore;
    ramstate_t   ramstate;

    typedef struct {
        bit          dport;
        bit          chk;
        logic [31:0] dat;
    } exp_t;

    exp_t sb[$];
    int   n_chk = 0;
    int   n_err = 0;

    cache_mem_arbiter #(.TIMEOUT_CYC(4), .ERR_WORD(ERRW)) dut (
        .CLK(CLK), .nRST(nRST),
        .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dwait(dwait), .dload(dload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr),
        .ramstore(ramstore), .ramload(ramload), .ramstate(ramstate),
        .bus_err(bus_err)
    );

    always #5 CLK = ~CLK;

    // Scoreboard: each queued entry must complete in the cycle it was queued;
    // with nothing queued, both waits must be high.
    always @(negedge CLK) begin
        exp_t e;
        n_chk++;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            if (e.dport) begin
                if (dwait !== 1'b0 || iwait !== 1'b1 || (e.chk && dload !== e.dat)) begin
                    n_err++;
                    $display("FAIL sb_d: dwait=%b iwait=%b dload=%h want dwait=0 iwait=1 dload=%h", dwait, iwait, dload, e.dat);
                end
            end else if (iwait !== 1'b0 || dwait !== 1'b1 || iload !== e.dat) begin
                n_err++;
                $display("FAIL sb_i: iwait=%b dwait=%b iload=%h want iwait=0 dwait=1 iload=%h", iwait, dwait, iload, e.dat);
            end
        end else if (iwait !== 1'b1 || dwait !== 1'b1) begin
            n_err++;
            $display("FAIL sb_idle: iwait=%b dwait=%b want 1 1 (unexpected completion)", iwait, dwait);
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        nRST = 1'b0; iREN = 0; dREN = 0; dWEN = 0;
        iaddr = 0; daddr = 0; dstore = 0; ramload = 0; ramstate = FREE;
        #2;
        n_chk++;
        if (iwait !== 1 || dwait !== 1 || ramREN !== 0 || ramWEN !== 0 || ramaddr !== 0 ||
            ramstore !== 0 || iload !== 0 || dload !== 0 || bus_err !== 0) begin
            n_err++;
            $display("FAIL reset_vals: iw=%b dw=%b ren=%b wen=%b addr=%h st=%h il=%h dl=%h be=%b want 1 1 0 0 0 0 0 0 0",
                     iwait, dwait, ramREN, ramWEN, ramaddr, ramstore, iload, dload, bus_err);
        end
        tick();
        nRST = 1'b1;
        @(negedge CLK);
        n_chk++;
        if (ramREN !== 0 || ramWEN !== 0) begin
            n_err++;
            $display("FAIL reset_release: ren=%b wen=%b want 0 0", ramREN, ramWEN);
        end
    endtask

    task automatic test_icache_read();
        tick(); iREN = 1; iaddr = 32'h40; ramstate = FREE;
        @(negedge CLK);
        n_chk++;
        if (ramREN !== 0) begin n_err++; $display("FAIL ird_c0: ramREN=%b want 0", ramREN); end
        for (int c = 1; c <= 3; c++) begin
            tick(); ramstate = BUSY;
            @(negedge CLK);
            n_chk++;
            if (ramREN !== 1 || ramWEN !== 0 || ramaddr !== 32'h40) begin
                n_err++;
                $display("FAIL ird_c%0d: ren=%b wen=%b addr=%h want 1 0 00000040", c, ramREN, ramWEN, ramaddr);
            end
        end
        // Fourth grant cycle also hits the timeout limit; ACCESS must win.
        tick(); ramstate = ACCESS; ramload = 32'h1234;
        sb.push_back('{1'b0, 1'b1, 32'h1234});
        @(negedge CLK);
        tick(); ramstate = FREE;
        @(negedge CLK);
        n_chk++;
        if (ramREN !== 0 || bus_err !== 0) begin
            n_err++;
            $display("FAIL ird_c5: ren=%b bus_err=%b want 0 0", ramREN, bus_err);
        end
        tick(); iREN = 0;
        tick();
    endtask

    task automatic test_dcache_write();
        tick(); dWEN = 1; dREN = 1; daddr = 32'h80; dstore = 32'hCAFEF00D; ramstate = ACCESS;
        @(negedge CLK);
        n_chk++;
        if (ramWEN !== 0) begin n_err++; $display("FAIL dwr_c0: ramWEN=%b want 0", ramWEN); end
        tick();
        sb.push_back('{1'b1, 1'b0, 32'h0});
        @(negedge CLK);
        n_chk++;
        if (ramWEN !== 1 || ramREN !== 0 || ramstore !== 32'hCAFEF00D || ramaddr !== 32'h80) begin
            n_err++;
            $display("FAIL dwr_c1: wen=%b ren=%b st=%h addr=%h want 1 0 cafef00d 00000080", ramWEN, ramREN, ramstore, ramaddr);
        end
        tick(); dWEN = 0; dREN = 0; ramstate = FREE;
        @(negedge CLK);
        n_chk++;
        if (ramWEN !== 0 || ramstore !== 0) begin
            n_err++;
            $display("FAIL dwr_c2: wen=%b st=%h want 0 0", ramWEN, ramstore);
        end
    endtask

    task automatic test_contention(input grant_t first);
        logic [31:0] a1, a2;
        a1 = (first == DATA) ? 32'h200 : 32'h100;
        a2 = (first == DATA) ? 32'h100 : 32'h200;
        tick(); iREN = 1; iaddr = 32'h100; dREN = 1; dWEN = 0; daddr = 32'h200;
        ramstate = ACCESS; ramload = 32'hA5A50001;
        @(negedge CLK);
        tick(); ramload = 32'hA5A50002;
        sb.push_back('{(first == DATA), 1'b1, 32'hA5A50002});
        @(negedge CLK);
        n_chk++;
        if (ramaddr !== a1 || ramREN !== 1) begin
            n_err++;
            $display("FAIL cont_first: addr=%h ren=%b want %h 1", ramaddr, ramREN, a1);
        end
        tick();
        if (first == DATA) dREN = 0; else iREN = 0;
        @(negedge CLK);
        n_chk++;
        if (ramREN !== 0) begin n_err++; $display("FAIL cont_gap: ramREN=%b want 0", ramREN); end
        tick(); ramload = 32'hA5A50003;
        sb.push_back('{(first != DATA), 1'b1, 32'hA5A50003});
        @(negedge CLK);
        n_chk++;
        if (ramaddr !== a2 || ramREN !== 1) begin
            n_err++;
            $display("FAIL cont_second: addr=%h ren=%b want %h 1", ramaddr, ramREN, a2);
        end
        tick(); iREN = 0; dREN = 0; ramstate = FREE;
        @(negedge CLK);
    endtask

    task automatic test_abort();
        tick(); dREN = 1; daddr = 32'h300; ramstate = BUSY;
        @(negedge CLK);
        tick();
        @(negedge CLK);
        n_chk++;
        if (ramREN !== 1 || ramaddr !== 32'h300) begin
            n_err++;
            $display("FAIL abort_grant: ren=%b addr=%h want 1 00000300", ramREN, ramaddr);
        end
        tick(); dREN = 0;
        @(negedge CLK);
        n_chk++;
        if (ramREN !== 0 || ramaddr !== 0) begin
            n_err++;
            $display("FAIL abort_drop: ren=%b addr=%h want 0 0", ramREN, ramaddr);
        end
        // Re-raise: must be back in IDLE, so no enable until the next edge.
        tick(); dREN = 1;
        @(negedge CLK);
        n_chk++;
        if (ramREN !== 0) begin n_err++; $display("FAIL abort_idle: ramREN=%b want 0", ramREN); end
        tick(); ramstate = ACCESS; ramload = 32'h600D;
        sb.push_back('{1'b1, 1'b1, 32'h600D});
        @(negedge CLK);
        tick(); dREN = 0; ramstate = FREE;
        @(negedge CLK);
    endtask

    task automatic test_timeout();
        tick(); iREN = 1; iaddr = 32'h700; ramstate = BUSY;
        @(negedge CLK);
        for (int c = 1; c <= 3; c++) begin
            tick();
            @(negedge CLK);
            n_chk++;
            if (ramREN !== 1 || bus_err !== 0) begin
                n_err++;
                $display("FAIL tmo_wait_c%0d: ren=%b bus_err=%b want 1 0", c, ramREN, bus_err);
            end
        end
        tick();
        sb.push_back('{1'b0, 1'b1, ERRW});
        @(negedge CLK);
        tick(); iREN = 0; ramstate = FREE;
        @(negedge CLK);
        n_chk++;
        if (bus_err !== 1) begin n_err++; $display("FAIL tmo_buserr: bus_err=%b want 1", bus_err); end
    endtask

    task automatic test_reset_mid();
        tick(); iREN = 1; iaddr = 32'h900; ramstate = BUSY;
        @(negedge CLK);
        tick();
        #2;
        nRST = 0; ramstate = ACCESS;
        #1;
        n_chk++;
        if (ramREN !== 0 || iwait !== 1 || dwait !== 1 || ramaddr !== 0 || bus_err !== 0) begin
            n_err++;
            $display("FAIL rst_mid: ren=%b iw=%b dw=%b addr=%h be=%b want 0 1 1 0 0", ramREN, iwait, dwait, ramaddr, bus_err);
        end
        tick(); iREN = 0; ramstate = FREE; nRST = 1;
        @(negedge CLK);
        n_chk++;
        if (ramREN !== 0 || bus_err !== 0) begin
            n_err++;
            $display("FAIL rst_after: ren=%b be=%b want 0 0", ramREN, bus_err);
        end
    endtask

    task automatic test_error();
        tick(); iREN = 1; iaddr = 32'h500; ramstate = BUSY;
        @(negedge CLK);
        tick();
        @(negedge CLK);
        tick(); ramstate = ERROR;
        sb.push_back('{1'b0, 1'b1, ERRW});
        @(negedge CLK);
        tick(); iREN = 0; ramstate = FREE;
        @(negedge CLK);
        n_chk++;
        if (bus_err !== 1) begin n_err++; $display("FAIL err_set: bus_err=%b want 1", bus_err); end
        tick(); dREN = 1; daddr = 32'h504; ramstate = ACCESS; ramload = 32'h7777;
        @(negedge CLK);
        tick();
        sb.push_back('{1'b1, 1'b1, 32'h7777});
        @(negedge CLK);
        tick(); dREN = 0; ramstate = FREE;
        @(negedge CLK);
        n_chk++;
        if (bus_err !== 1) begin n_err++; $display("FAIL err_sticky: bus_err=%b want 1", bus_err); end
    endtask

    initial begin
        test_reset();
        test_icache_read();
        test_contention(DATA);   // last_grant is INSTR here
        test_dcache_write();
        test_contention(INSTR);  // last_grant is DATA here
        test_abort();
        test_timeout();
        test_reset_mid();
        test_error();
        tick();
        n_chk++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL sb_drain: %0d entries left want 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
